// File: rtl/bf16_pkg.sv
// Shared BF16 datapath types and widths.
// Shared by the normaliser scheduler, its core and the lzc.
package bf16_pkg;

  localparam int BF16_MW = 8;
  localparam int BF16_EW = 8;
  localparam int EXT_MW  = 16;
  localparam int MAX_ID_W = 3;

  function automatic int cw(input int mw);
    return $clog2(mw + 1);
  endfunction

  typedef struct packed {
    logic [EXT_MW-1:0]   mant;
    logic [BF16_EW-1:0]  exp;
    logic [MAX_ID_W-1:0] id;
  } norm_req_t;

endpackage

// File: rtl/bf16_lzc.sv
// Leading-zero counter; returns W when the input is all zero.
// The highest set bit wins, so the last match in the scan is kept.
module bf16_lzc
  import bf16_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = cw(W)
) (
  input  logic [W-1:0]  a_i,
  output logic [CW-1:0] cnt_o
);

  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (a_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/bf16_norm_core.sv
// Combinational normalise: shift out leading zeros, adjust exponent.
// Zero mantissa wins over exponent underflow.
module bf16_norm_core
  import bf16_pkg::*;
#(
  parameter int MW = 16,
  parameter int EW = 8,
  parameter int CW = cw(MW)
) (
  input  logic [MW-1:0] mant_i,
  input  logic [EW-1:0] exp_i,
  output logic [MW-1:0] mant_o,
  output logic [EW-1:0] exp_o,
  output logic          zero_o,
  output logic          uf_o
);

  localparam int XW = (EW > CW) ? EW : CW;

  logic [CW-1:0] cnt;
  logic [XW-1:0] cnt_x;
  logic [XW-1:0] exp_x;

  bf16_lzc #(.W(MW), .CW(CW)) u_lzc (
    .a_i  (mant_i),
    .cnt_o(cnt)
  );

  assign cnt_x = XW'(cnt);
  assign exp_x = XW'(exp_i);

  always_comb begin
    mant_o = '0;
    exp_o  = '0;
    zero_o = 1'b0;
    uf_o   = 1'b0;
    if (cnt == CW'(MW)) begin
      zero_o = 1'b1;
    end else if (cnt_x >= exp_x) begin
      uf_o = 1'b1;
    end else begin
      mant_o = mant_i << cnt;
      exp_o  = EW'(exp_x - cnt_x);
    end
  end

endmodule

// File: rtl/bf16_norm_sched.sv
// Round-robin shared normaliser: arbiter, S1 capture, S2 result.
// Results return tagged with the requester ID over valid/ready.
module bf16_norm_sched
  import bf16_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int MW    = 16,
  parameter int EW    = 8,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid_i,
  input  logic [N_REQ*MW-1:0] req_mant_i,
  input  logic [N_REQ*EW-1:0] req_exp_i,
  output logic [N_REQ-1:0]    req_ready_o,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [MW-1:0]       res_mant_o,
  output logic [EW-1:0]       res_exp_o,
  output logic [ID_W-1:0]     res_id_o,
  output logic                res_zero_o,
  output logic                res_uf_o
);

  localparam int CW = cw(MW);

  typedef struct packed {
    logic [MW-1:0]   mant;
    logic [EW-1:0]   exp;
    logic [ID_W-1:0] id;
  } s1_t;

  s1_t             s1_q, s1_d;
  logic            s1_v_q, s1_v_d;
  logic [ID_W-1:0] ptr_q, ptr_d;

  logic            res_v_q;
  logic [MW-1:0]   res_mant_q;
  logic [EW-1:0]   res_exp_q;
  logic [ID_W-1:0] res_id_q;
  logic            res_zero_q, res_uf_q;

  logic             adv2, s1_acc, xfer, gnt_found;
  logic [ID_W-1:0]  gnt_id;
  logic [N_REQ-1:0] gnt_oh;

  logic [MW-1:0] n_mant;
  logic [EW-1:0] n_exp;
  logic          n_zero, n_uf;

  assign adv2   = s1_v_q & (~res_v_q | res_ready_i);
  assign s1_acc = ~s1_v_q | adv2;

  // Scan from the pointer upward with wrap-around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    gnt_oh    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int k;
      k = int'(ptr_q) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (!gnt_found && req_valid_i[k]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(k);
      end
    end
    if (gnt_found) gnt_oh[gnt_id] = 1'b1;
  end

  assign req_ready_o = gnt_oh & {N_REQ{s1_acc & ~rst}};
  assign xfer        = |(req_valid_i & req_ready_o);

  always_comb begin
    s1_d      = s1_q;
    s1_v_d    = s1_v_q;
    ptr_d     = ptr_q;
    if (s1_acc) s1_v_d = xfer;
    if (xfer) begin
      s1_d.mant = req_mant_i[gnt_id*MW +: MW];
      s1_d.exp  = req_exp_i[gnt_id*EW +: EW];
      s1_d.id   = gnt_id;
      ptr_d     = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  bf16_norm_core #(.MW(MW), .EW(EW), .CW(CW)) u_core (
    .mant_i(s1_q.mant),
    .exp_i (s1_q.exp),
    .mant_o(n_mant),
    .exp_o (n_exp),
    .zero_o(n_zero),
    .uf_o  (n_uf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q       <= '0;
      s1_v_q     <= 1'b0;
      ptr_q      <= '0;
      res_v_q    <= 1'b0;
      res_mant_q <= '0;
      res_exp_q  <= '0;
      res_id_q   <= '0;
      res_zero_q <= 1'b0;
      res_uf_q   <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s1_v_q <= s1_v_d;
      ptr_q  <= ptr_d;
      if (adv2) begin
        res_v_q    <= 1'b1;
        res_mant_q <= n_mant;
        res_exp_q  <= n_exp;
        res_id_q   <= s1_q.id;
        res_zero_q <= n_zero;
        res_uf_q   <= n_uf;
      end else if (res_ready_i) begin
        res_v_q <= 1'b0;
      end
    end
  end

  assign res_valid_o = res_v_q;
  assign res_mant_o  = res_mant_q;
  assign res_exp_o   = res_exp_q;
  assign res_id_o    = res_id_q;
  assign res_zero_o  = res_zero_q;
  assign res_uf_o    = res_uf_q;

endmodule

// File: tb/tb_bf16_norm_sched.sv
// Bench for bf16_norm_sched: boundary table plus scoreboarded
// sequences for fairness, backpressure, pointer wrap and reset.
module tb_bf16_norm_sched;

  localparam int N  = 4;
  localparam int MW = 16;
  localparam int EW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*MW-1:0] req_mant = '0;
  logic [N*EW-1:0] req_exp = '0;
  logic            res_valid;
  logic            res_ready = 1'b1;
  logic [MW-1:0]   res_mant;
  logic [EW-1:0]   res_exp;
  logic [IW-1:0]   res_id;
  logic            res_zero, res_uf;

  always #5 clk = ~clk;

  bf16_norm_sched #(.N_REQ(N), .MW(MW), .EW(EW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid_i(req_valid),
    .req_mant_i (req_mant),
    .req_exp_i  (req_exp),
    .req_ready_o(req_ready),
    .res_valid_o(res_valid),
    .res_ready_i(res_ready),
    .res_mant_o (res_mant),
    .res_exp_o  (res_exp),
    .res_id_o   (res_id),
    .res_zero_o (res_zero),
    .res_uf_o   (res_uf)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [MW-1:0] mant;
    logic [EW-1:0] exp;
    logic          zero;
    logic          uf;
  } res_t;

  typedef struct {
    logic [MW-1:0] m;
    logic [EW-1:0] e;
    logic [MW-1:0] xm;
    logic [EW-1:0] xe;
    logic          z;
    logic          u;
  } vec_t;

  res_t sb[$];
  int   gq[$];
  int   tests = 0;
  int   fails = 0;

  function automatic res_t model(int id, logic [MW-1:0] m,
                                 logic [EW-1:0] e);
    res_t r;
    int   c;
    r = '0;
    r.id = IW'(id);
    c = 0;
    while (c < MW && m[MW-1-c] == 1'b0) c++;
    if (c == MW) r.zero = 1'b1;
    else if (c >= int'(e)) r.uf = 1'b1;
    else begin
      r.mant = m << c;
      r.exp  = e - EW'(c);
    end
    return r;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_extra: got id %0d expected none", res_id);
        end else begin
          res_t e;
          e = sb.pop_front();
          chk("sb_result",
              {res_id, res_mant, res_exp, res_zero, res_uf}, e);
        end
      end
      for (int k = 0; k < N; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          sb.push_back(model(k, req_mant[k*MW +: MW],
                             req_exp[k*EW +: EW]));
          gq.push_back(k);
        end
      end
    end
  end

  task automatic set_req(int k, logic [MW-1:0] m, logic [EW-1:0] e);
    req_mant[k*MW +: MW] = m;
    req_exp[k*EW +: EW]  = e;
    req_valid[k]         = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    sb.delete();
    gq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One cycle; requesters drop valid after their transfer.
  task automatic step();
    logic [N-1:0] x;
    @(negedge clk);
    x = req_valid & req_ready;
    @(posedge clk);
    #1 req_valid = req_valid & ~x;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0 && req_valid == '0 && !res_valid) break;
      step();
    end
    chk("drain", {sb.size() == 0, req_valid}, {1'b1, 4'h0});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[9];
    int   lat;
    int   vcnt;
    logic [63:0] snap;

    tv[0] = '{16'h00F0, 8'd20, 16'hF000, 8'd12, 1'b0, 1'b0};
    tv[1] = '{16'h0000, 8'd50, 16'h0000, 8'd0,  1'b1, 1'b0};
    tv[2] = '{16'h0001, 8'd15, 16'h0000, 8'd0,  1'b0, 1'b1};
    tv[3] = '{16'h0001, 8'd16, 16'h8000, 8'd1,  1'b0, 1'b0};
    tv[4] = '{16'h8000, 8'd7,  16'h8000, 8'd7,  1'b0, 1'b0};
    tv[5] = '{16'h8000, 8'd0,  16'h0000, 8'd0,  1'b0, 1'b1};
    tv[6] = '{16'h0000, 8'd0,  16'h0000, 8'd0,  1'b1, 1'b0};
    tv[7] = '{16'h0100, 8'd8,  16'h8000, 8'd1,  1'b0, 1'b0};
    tv[8] = '{16'h0100, 8'd7,  16'h0000, 8'd0,  1'b0, 1'b1};

    req_valid = 4'hF;
    #1;
    chk("rst_outputs",
        {res_valid, res_id, res_mant, res_exp, res_zero, res_uf}, 0);
    chk("rst_ready", req_ready, 4'h0);
    do_reset();

    res_ready = 1'b1;
    foreach (tv[i]) begin
      @(posedge clk);
      #1 set_req(0, tv[i].m, tv[i].e);
      @(negedge clk);
      chk("tab_ready", req_ready, 4'h1);
      @(posedge clk);
      #1 req_valid = '0;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!res_valid && lat < 10);
      chk("tab_latency", lat, 2);
      chk("tab_result",
          {res_id, res_mant, res_exp, res_zero, res_uf},
          {2'd0, tv[i].xm, tv[i].xe, tv[i].z, tv[i].u});
    end
    wait_drain();

    do_reset();
    res_ready = 1'b1;
    vcnt = 0;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++)
      set_req(k, 16'h0100 >> k, 8'(30 + k));
    repeat (8) begin
      @(negedge clk);
      if (res_valid) vcnt++;
    end
    @(posedge clk);
    #1 req_valid = '0;
    chk("rr_grants", gq.size(), 8);
    for (int i = 0; i < 8 && i < gq.size(); i++)
      chk("rr_order", gq[i], i % 4);
    chk("rr_throughput", vcnt, 6);
    wait_drain();

    do_reset();
    res_ready = 1'b0;
    set_req(0, 16'h0003, 8'd40);
    set_req(1, 16'h0000, 8'd9);
    set_req(2, 16'h1234, 8'd2);
    step();
    step();
    snap = {res_valid, res_id, res_mant, res_exp, res_zero, res_uf};
    chk("bp_valid", res_valid, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready", req_ready, 4'h0);
      chk("bp_stable",
          {res_valid, res_id, res_mant, res_exp, res_zero, res_uf},
          snap);
      chk("bp_buffered", sb.size(), 2);
      @(posedge clk);
      #1;
    end
    res_ready = 1'b1;
    wait_drain();
    chk("bp_order", {gq.size(), gq[0], gq[1], gq[2]}, {32'd3, 32'd0, 32'd1, 32'd2});

    do_reset();
    res_ready = 1'b1;
    set_req(3, 16'h0F00, 8'd20);
    step();
    set_req(0, 16'h00FF, 8'd20);
    set_req(3, 16'h0F0F, 8'd21);
    @(negedge clk);
    chk("wrap_grant", req_ready, 4'h1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_drain();
    chk("wrap_order", {gq.size(), gq[0], gq[1], gq[2]}, {32'd3, 32'd3, 32'd0, 32'd3});

    res_ready = 1'b0;
    for (int k = 0; k < N; k++)
      set_req(k, 16'h0040 << k, 8'd60);
    step();
    step();
    @(negedge clk);
    chk("mid_full", {res_valid, req_ready}, {1'b1, 4'h0});
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_outputs",
        {res_valid, res_id, res_mant, res_exp, res_zero, res_uf}, 0);
    chk("mid_rst_ready", req_ready, 4'h0);
    sb.delete();
    gq.delete();
    req_valid = 4'hF;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_grant", req_ready, 4'h1);
    chk("post_rst_nostale", res_valid, 1'b0);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_drain();
    chk("post_rst_order",
        {gq.size(), gq[0], gq[1], gq[2], gq[3]},
        {32'd4, 32'd0, 32'd1, 32'd2, 32'd3});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
